hazard_control_unit: RTL

Pipeline stall/flush controller for the 5-stage MIPS pipeline, sitting beside the forwarding unit. It handles the hazards forwarding cannot resolve: load-use dependencies, taken branches resolved in EX, and multi-cycle data-memory accesses in MEM. It drives the write-enable, flush and bubble controls of the PC and every pipeline register. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_control_unit_if.sv | 38 +++
 rtl/hazard_control_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hazard_control_unit_if.sv
// Bundle of hazard-unit inputs (instruction fields, hazard qualifiers, memory handshake)
// and the pipeline register controls it drives.
interface hazard_control_unit_if #(
    parameter int unsigned INST_W = 19,
    parameter int unsigned CNT_W  = 16
);
    logic [INST_W-1:0] ID_inst;
    logic              reg2_read_source;
    logic [INST_W-1:0] EX_inst;
    logic              EX_mem_read;
    logic              EX_reg_write_signal;
    logic              branch_taken;
    logic              MEM_mem_access;
    logic              mem_ready;
    logic              pc_write;
    logic              IF_ID_write;
    logic              ID_EX_write;
    logic              EX_MEM_write;
    logic              MEM_WB_write;
    logic              IF_ID_flush;
    logic              ID_EX_bubble;
    logic [CNT_W-1:0]  stall_cycles;
    logic              mem_timeout;

    modport master (
        output ID_inst, reg2_read_source, EX_inst, EX_mem_read, EX_reg_write_signal,
               branch_taken, MEM_mem_access, mem_ready,
        input  pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
               IF_ID_flush, ID_EX_bubble, stall_cycles, mem_timeout
    );

    modport slave (
        input  ID_inst, reg2_read_source, EX_inst, EX_mem_read, EX_reg_write_signal,
               branch_taken, MEM_mem_access, mem_ready,
        output pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
               IF_ID_flush, ID_EX_bubble, stall_cycles, mem_timeout
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// multi-cycle memory freezes with deferred flush, stall-cycle counter and memory timeout flag.
module hazard_control_unit #(
    parameter int unsigned INST_W  = 19,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_control_unit_if.slave bus
);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] W_MAX = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] W_PRE = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] W_ONE = WCNT_W'(1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pending_flush;
    logic                w_pending_nxt;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [WCNT_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic                r_mem_timeout;
    logic                w_timeout_nxt;

    logic [2:0]          w_dest_ex;
    logic [2:0]          w_src_b;
    logic                w_load_use;
    logic                w_mem_stall;
    logic                w_br;
    logic                w_pc_write;
    logic                w_if_id_write;
    logic                w_id_ex_write;
    logic                w_ex_mem_write;
    logic                w_mem_wb_write;
    logic                w_if_id_flush;
    logic                w_id_ex_bubble;
    logic                w_unused_bits;

    assign w_unused_bits = ^{bus.ID_inst[INST_W-1:14], bus.ID_inst[4:0],
                             bus.EX_inst[INST_W-1:14], bus.EX_inst[10:0]};

    assign w_dest_ex   = bus.EX_inst[13:11];
    assign w_src_b     = bus.reg2_read_source ? bus.ID_inst[10:8] : bus.ID_inst[7:5];
    assign w_load_use  = bus.EX_mem_read & bus.EX_reg_write_signal & (w_dest_ex != 3'd0) &
                         ((w_dest_ex == bus.ID_inst[10:8]) | (w_dest_ex == w_src_b));
    assign w_mem_stall = bus.MEM_mem_access & ~bus.mem_ready;
    assign w_br        = bus.branch_taken | r_pending_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending_flush;
        w_wait_nxt     = r_wait_cnt;
        w_timeout_nxt  = r_mem_timeout;
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_write  = 1'b1;
        w_ex_mem_write = 1'b1;
        w_mem_wb_write = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        if ((r_state == RUN && w_mem_stall) || (r_state == MEM_WAIT && !bus.mem_ready)) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_mem_wb_write = 1'b0;
            // A branch seen while frozen is remembered and flushed when memory completes
            w_pending_nxt  = r_pending_flush | bus.branch_taken;
            w_state_nxt    = MEM_WAIT;
            if (r_state == RUN) begin
                w_wait_nxt = W_ONE;
            end else begin
                if (r_wait_cnt < W_MAX) w_wait_nxt = r_wait_cnt + W_ONE;
                if (r_wait_cnt >= W_PRE) w_timeout_nxt = 1'b1;
            end
        end else begin
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
            if (w_br) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
                w_pending_nxt  = 1'b0;
            end else if (w_load_use) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending_flush <= 1'b0;
            r_wait_cnt      <= '0;
            r_mem_timeout   <= 1'b0;
            r_stall_cycles  <= '0;
        end else begin
            r_pending_flush <= w_pending_nxt;
            r_wait_cnt      <= w_wait_nxt;
            r_mem_timeout   <= w_timeout_nxt;
            if (!w_pc_write && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    // Controls are Mealy; gating with rst_n forces them idle during reset
    assign bus.pc_write     = rst_n & w_pc_write;
    assign bus.IF_ID_write  = rst_n & w_if_id_write;
    assign bus.ID_EX_write  = rst_n & w_id_ex_write;
    assign bus.EX_MEM_write = rst_n & w_ex_mem_write;
    assign bus.MEM_WB_write = rst_n & w_mem_wb_write;
    assign bus.IF_ID_flush  = rst_n & w_if_id_flush;
    assign bus.ID_EX_bubble = rst_n & w_id_ex_bubble;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.mem_timeout  = r_mem_timeout;
endmodule
